// File: rtl/rx_slicer_4ask_pkg.sv
// Shared types and constants for the 4-ASK receive slicer.
// Symbol codes, the 18-bit 1s17 sample type and the averaging default live here.
package rx_slicer_pkg;

   localparam int unsigned SAMPLE_W         = 18;
   localparam int unsigned AVG_LOG2_DEFAULT = 12;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      SYM_M3A = 2'b00,
      SYM_M1A = 2'b01,
      SYM_P1A = 2'b10,
      SYM_P3A = 2'b11
   } sym_code_t;

   typedef enum logic {
      ST_ACQUIRE = 1'b0,
      ST_TRACK   = 1'b1
   } avg_state_t;

   // |x| with the single unrepresentable magnitude (-2^17) clipped to 2^17-1.
   function automatic logic [SAMPLE_W-1:0] abs_sat(input sample_t x);
      if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
         return {1'b0, {(SAMPLE_W-1){1'b1}}};
      else if (x[SAMPLE_W-1])
         return $unsigned(-x);
      else
         return $unsigned(x);
   endfunction

endpackage

// File: rtl/rx_slicer_4ask_if.sv
// Slicer bus bundle: strobed matched-filter sample in, decision and level status out.
// The err signal exists only when SLICER_ERR_EN is defined.
interface rx_slicer_4ask_if;
   import rx_slicer_pkg::*;

   logic      sam_clk_en;
   logic      sym_clk_en;
   sample_t   in;
   sym_code_t sym_out;
   logic      sym_valid;
   sample_t   ref_level;
   logic      locked;

`ifdef SLICER_ERR_EN
   sample_t   err;

   modport master (
      output sam_clk_en, sym_clk_en, in,
      input  sym_out, sym_valid, ref_level, locked, err
   );

   modport slave (
      input  sam_clk_en, sym_clk_en, in,
      output sym_out, sym_valid, ref_level, locked, err
   );
`else
   modport master (
      output sam_clk_en, sym_clk_en, in,
      input  sym_out, sym_valid, ref_level, locked
   );

   modport slave (
      input  sam_clk_en, sym_clk_en, in,
      output sym_out, sym_valid, ref_level, locked
   );
`endif

endinterface

// File: rtl/rx_slicer_4ask_level_averager.sv
// Block-average of |x| producing the slicer reference level (estimated 2a)
// and the ACQUIRE/TRACK lock state.
module level_averager
   import rx_slicer_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = AVG_LOG2_DEFAULT,
   parameter sample_t     REF_INIT = 18'sd65536
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    samp_valid,
   input  sample_t samp,
   output sample_t ref_level,
   output logic    locked
);

   localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;

   avg_state_t          state;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [AVG_LOG2-1:0] cnt;
   logic [SAMPLE_W-1:0] mag;
   logic                wrap;

   always_comb begin
      mag     = abs_sat(samp);
      acc_sum = acc + ACC_W'(mag);
      wrap    = samp_valid && (cnt == '1);
   end

   // The wrapping sample is folded into the average, then the block restarts empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_ACQUIRE;
         acc       <= '0;
         cnt       <= '0;
         ref_level <= REF_INIT;
         locked    <= 1'b0;
      end else begin
         if (samp_valid) begin
            cnt <= cnt + AVG_LOG2'(1);
            if (wrap) begin
               acc       <= '0;
               ref_level <= sample_t'(acc_sum >> AVG_LOG2);
            end else begin
               acc <= acc_sum;
            end
         end

         case (state)
            ST_ACQUIRE: begin
               locked <= 1'b0;
               if (wrap) begin
                  state  <= ST_TRACK;
                  locked <= 1'b1;
               end
            end
            ST_TRACK: begin
               locked <= 1'b1;
            end
            default: begin
               state  <= ST_ACQUIRE;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rx_slicer_4ask.sv
// 4-ASK symbol slicer: captures the symbol-strobed sample, slices it against a
// block-averaged reference level. Optional decision-error output under SLICER_ERR_EN.
module rx_slicer_4ask
   import rx_slicer_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = AVG_LOG2_DEFAULT,
   parameter sample_t     REF_INIT = 18'sd65536
) (
   input  logic             clk,
   input  logic             reset,
   rx_slicer_4ask_if.slave  bus
);

   logic                     strobe;
   logic                     cap_valid;
   sample_t                  cap_x;
   sample_t                  ref_level;
   logic                     locked;
   logic signed [SAMPLE_W:0] x_w;
   logic signed [SAMPLE_W:0] ref_w;
   sym_code_t                dec;

   assign strobe = bus.sam_clk_en && bus.sym_clk_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_valid <= 1'b0;
         cap_x     <= '0;
      end else begin
         cap_valid <= strobe;
         if (strobe)
            cap_x <= bus.in;
      end
   end

   // The averager updates on the same edge the decision registers, so the
   // decision always sees the level from before this sample's contribution.
   level_averager #(
      .AVG_LOG2 (AVG_LOG2),
      .REF_INIT (REF_INIT)
   ) u_level_averager (
      .clk        (clk),
      .reset      (reset),
      .samp_valid (cap_valid),
      .samp       (cap_x),
      .ref_level  (ref_level),
      .locked     (locked)
   );

   always_comb begin
      x_w   = {cap_x[SAMPLE_W-1], cap_x};
      ref_w = {ref_level[SAMPLE_W-1], ref_level};
      if (x_w >= ref_w)
         dec = SYM_P3A;
      else if (!x_w[SAMPLE_W])
         dec = SYM_P1A;
      else if (x_w >= -ref_w)
         dec = SYM_M1A;
      else
         dec = SYM_M3A;
   end

`ifdef SLICER_ERR_EN
   localparam logic signed [SAMPLE_W+2:0] ERR_MAX = 21'sd131071;
   localparam logic signed [SAMPLE_W+2:0] ERR_MIN = -21'sd131072;

   logic signed [SAMPLE_W+2:0] x_e;
   logic signed [SAMPLE_W+2:0] r_e;
   logic signed [SAMPLE_W+2:0] lvl;
   logic signed [SAMPLE_W+2:0] diff;
   sample_t                    err_sat;

   always_comb begin
      x_e = (SAMPLE_W+3)'(cap_x);
      r_e = (SAMPLE_W+3)'(ref_level);
      case (dec)
         SYM_P3A: lvl = (r_e + (r_e <<< 1)) >>> 1;
         SYM_P1A: lvl = r_e >>> 1;
         SYM_M1A: lvl = -(r_e >>> 1);
         default: lvl = -((r_e + (r_e <<< 1)) >>> 1);
      endcase
      diff = x_e - lvl;
      if (diff > ERR_MAX)
         err_sat = sample_t'(ERR_MAX);
      else if (diff < ERR_MIN)
         err_sat = sample_t'(ERR_MIN);
      else
         err_sat = diff[SAMPLE_W-1:0];
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.sym_out   <= SYM_M3A;
         bus.sym_valid <= 1'b0;
`ifdef SLICER_ERR_EN
         bus.err       <= '0;
`endif
      end else begin
         bus.sym_valid <= cap_valid;
         if (cap_valid) begin
            bus.sym_out <= dec;
`ifdef SLICER_ERR_EN
            bus.err     <= err_sat;
`endif
         end
      end
   end

   assign bus.ref_level = ref_level;
   assign bus.locked    = locked;

endmodule

// File: tb/tb_rx_slicer_4ask.sv
// Self-checking bench for rx_slicer_4ask (AVG_LOG2=4, REF_INIT=65536).
// Table vectors plus a reference-model scoreboard; err checks under SLICER_ERR_EN.
module tb_rx_slicer_4ask;
   import rx_slicer_pkg::*;

   typedef struct {
      sym_code_t sym;
      int        ref_lv;
      bit        lock;
      int        err;
      int        cyc;
   } exp_t;

   typedef struct {
      int        x;
      sym_code_t sym;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   nvalid = 0;
   exp_t sb[$];

   int ref_m, acc_m, cnt_m;
   bit lock_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rx_slicer_4ask_if bus();

   rx_slicer_4ask #(
      .AVG_LOG2 (4),
      .REF_INIT (18'sd65536)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic sym_code_t model_dec(input int x, input int r);
      if (x >= r)       return SYM_P3A;
      else if (x >= 0)  return SYM_P1A;
      else if (x >= -r) return SYM_M1A;
      else              return SYM_M3A;
   endfunction

   function automatic int model_err(input int x, input sym_code_t s, input int r);
      int lvl, d;
      case (s)
         SYM_P3A: lvl = (3 * r) >>> 1;
         SYM_P1A: lvl = r >>> 1;
         SYM_M1A: lvl = -(r >>> 1);
         default: lvl = -((3 * r) >>> 1);
      endcase
      d = x - lvl;
      if (d > 131071)  d = 131071;
      if (d < -131072) d = -131072;
      return d;
   endfunction

   // Monitor: every sym_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus.sym_valid === 1'b1) begin
         nvalid++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got sym_valid=1 expected 0 (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("sym_out", int'(bus.sym_out), int'(e.sym));
            chk("latency", cyc, e.cyc);
            chk("ref_level", int'(bus.ref_level), e.ref_lv);
            chk("locked", int'(bus.locked), int'(e.lock));
`ifdef SLICER_ERR_EN
            chk("err", int'(bus.err), e.err);
`endif
         end
      end
   end

   task automatic do_strobe(input int x, input bit push, input bit use_tab, input sym_code_t tab_sym);
      exp_t e;
      int   mag;
      @(negedge clk);
      bus.sam_clk_en = 1'b1;
      bus.sym_clk_en = 1'b1;
      bus.in         = sample_t'(x);
      if (push) begin
         e.sym = use_tab ? tab_sym : model_dec(x, ref_m);
         e.err = model_err(x, e.sym, ref_m);
         mag = (x == -131072) ? 131071 : ((x < 0) ? -x : x);
         if (cnt_m == 15) begin
            ref_m  = (acc_m + mag) >> 4;
            acc_m  = 0;
            cnt_m  = 0;
            lock_m = 1'b1;
         end else begin
            acc_m += mag;
            cnt_m++;
         end
         e.ref_lv = ref_m;
         e.lock   = lock_m;
         e.cyc    = cyc + 2;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.sam_clk_en = 1'b0;
         bus.sym_clk_en = 1'b0;
      end
   endtask

   task automatic drain();
      int waited = 0;
      idle(1);
      while (sb.size() != 0 && waited < 20) begin
         idle(1);
         waited++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d outstanding symbols expected 0", sb.size());
         sb.delete();
      end
      idle(2);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.sam_clk_en = 1'b0;
      bus.sym_clk_en = 1'b0;
      reset = 1'b1;
      ref_m  = 65536;
      acc_m  = 0;
      cnt_m  = 0;
      lock_m = 1'b0;
      #1;
      chk("rst_sym_out", int'(bus.sym_out), 0);
      chk("rst_sym_valid", int'(bus.sym_valid), 0);
      chk("rst_ref_level", int'(bus.ref_level), 65536);
      chk("rst_locked", int'(bus.locked), 0);
      idle(2);
      reset = 1'b0;
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[6];
      int   nv0;
      int   x;

      tv[0] = '{ 65536, SYM_P3A};
      tv[1] = '{ 65535, SYM_P1A};
      tv[2] = '{     0, SYM_P1A};
      tv[3] = '{    -1, SYM_M1A};
      tv[4] = '{-65536, SYM_M1A};
      tv[5] = '{-65537, SYM_M3A};

      reset = 1'b1;
      bus.sam_clk_en = 1'b0;
      bus.sym_clk_en = 1'b0;
      bus.in = '0;
      idle(3);

      // Reset state, then 8 strobes while reset is held
      do_reset();
      reset = 1'b1;
      nv0 = nvalid;
      for (int i = 0; i < 8; i++) do_strobe(1000 * i, 1'b0, 1'b0, SYM_M3A);
      idle(4);
      chk("valid_in_reset", nvalid - nv0, 0);
      reset = 1'b0;
      idle(2);

      // Threshold table, isolated strobes
      do_reset();
      for (int i = 0; i < 6; i++) begin
         do_strobe(tv[i].x, 1'b1, 1'b1, tv[i].sym);
         idle(2);
      end
      drain();

      // Averaging block: 16th decision still sliced against 65536
      do_reset();
      for (int i = 0; i < 15; i++) do_strobe((i % 2 == 0) ? 98304 : -98304, 1'b1, 1'b0, SYM_M3A);
      do_strobe(-98304, 1'b1, 1'b1, SYM_M3A);
      drain();
      chk("avg_ref_level", int'(bus.ref_level), 98304);
      chk("avg_locked", int'(bus.locked), 1);
      do_strobe(80000, 1'b1, 1'b1, SYM_P1A);
      drain();

      // Saturation of |-131072|
      do_reset();
      for (int i = 0; i < 16; i++) do_strobe(-131072, 1'b1, 1'b1, SYM_M3A);
      drain();
      chk("sat_ref_level", int'(bus.ref_level), 131071);

      // Enables: lone sym_clk_en / sam_clk_en never capture
      do_reset();
      nv0 = nvalid;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.sym_clk_en = (i % 2 == 0);
         bus.sam_clk_en = (i % 2 != 0);
         bus.in = sample_t'(40000);
      end
      drain();
      chk("lone_enables", nvalid - nv0, 0);

      // Strobe whose decision is still in flight when reset hits
      nv0 = nvalid;
      do_strobe(70000, 1'b0, 1'b0, SYM_M3A);
      do_reset();
      idle(3);
      chk("inflight_reset", nvalid - nv0, 0);

      // Reset mid-block restarts the block count
      for (int i = 0; i < 10; i++) begin
         do_strobe(50000, 1'b1, 1'b0, SYM_M3A);
         idle(1);
      end
      drain();
      do_reset();
      for (int i = 0; i < 15; i++) do_strobe(50000, 1'b1, 1'b0, SYM_M3A);
      drain();
      chk("midblk_locked15", int'(bus.locked), 0);
      do_strobe(50000, 1'b1, 1'b0, SYM_M3A);
      drain();
      chk("midblk_locked16", int'(bus.locked), 1);
      chk("midblk_ref_level", int'(bus.ref_level), 50000);

      // Random traffic across several block wraps
      do_reset();
      for (int i = 0; i < 48; i++) begin
         x = int'($urandom_range(262143)) - 131072;
         do_strobe(x, 1'b1, 1'b0, SYM_M3A);
         idle(int'($urandom_range(2)));
      end
      drain();

`ifdef SLICER_ERR_EN
      do_reset();
      do_strobe(100000, 1'b1, 1'b0, SYM_M3A);
      drain();
      chk("err_100000", int'(bus.err), 1696);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
